// File: rtl/prog_srl_fifo_if.sv
// prog_srl_fifo_if
//   Handshake/status bundle for prog_srl_fifo.
//   master : drives wr, rd, clr_err, din; observes data and status
//   slave  : the FIFO; drives dout, count and all flags
interface prog_srl_fifo_if #(
   parameter int WIDTH = 9,
   parameter int AW    = 4
);
   logic             wr;
   logic             rd;
   logic             clr_err;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             empty;
   logic             full;
   logic             almost_empty;
   logic             almost_full;
   logic [AW:0]      count;
   logic             overflow;
   logic             underflow;

   modport master (
      output wr, rd, clr_err, din,
      input  dout, empty, full, almost_empty, almost_full, count,
             overflow, underflow
   );

   modport slave (
      input  wr, rd, clr_err, din,
      output dout, empty, full, almost_empty, almost_full, count,
             overflow, underflow
   );
endinterface

// File: rtl/prog_srl_fifo.sv
// prog_srl_fifo
//   First-word-fall-through FIFO built on a shift register (no reset on the
//   data array so it maps onto SRL primitives). A write shifts every entry up
//   one slot and drops din into entry 0; the oldest word therefore sits at
//   entry count-1, which is what dout shows.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset (clears count and error flags only)
//     bus  - prog_srl_fifo_if.slave: wr/rd/clr_err/din in;
//            dout, count, empty/full, almost_empty/almost_full,
//            sticky overflow/underflow out
module prog_srl_fifo #(
   parameter int WIDTH    = 9,
   parameter int AW       = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic             clk,
   input  logic             rst,
   prog_srl_fifo_if.slave   bus
);
   localparam int          DEPTH    = 2 ** AW;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
   localparam logic [AW:0] AF_CNT   = AF_LEVEL[AW:0];
   localparam logic [AW:0] AE_CNT   = AE_LEVEL[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      cnt;
   logic [AW:0]      cnt_next;
   logic [AW-1:0]    ra_idx;
   logic             is_empty;
   logic             is_full;
   logic             wa;
   logic             ra_ok;
   logic             wr_rej;
   logic             rd_rej;
   logic             ovf;
   logic             unf;

   assign is_empty = (cnt == '0);
   assign is_full  = (cnt == FULL_CNT);

   // A write into a full FIFO is still accepted when a read pops the same
   // cycle: the shift pushes the oldest word out of the top entry.
   assign wa     = bus.wr & (~is_full | bus.rd);
   assign ra_ok  = bus.rd & ~is_empty;
   assign wr_rej = bus.wr & is_full & ~bus.rd;
   assign rd_rej = bus.rd & is_empty;

   // Low bits only: at count == DEPTH they are zero and wrap to DEPTH-1.
   assign ra_idx = cnt[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (wa && !rst) begin
         mem[0] <= bus.din;
         for (int i = DEPTH - 1; i > 0; i--) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   always_comb begin
      cnt_next = cnt;
      unique case ({wa, ra_ok})
         2'b10:   cnt_next = cnt + {{AW{1'b0}}, 1'b1};
         2'b01:   cnt_next = cnt - {{AW{1'b0}}, 1'b1};
         default: cnt_next = cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

   // Sticky errors: a new error in the same cycle as clr_err keeps the flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         if (wr_rej) begin
            ovf <= 1'b1;
         end else if (bus.clr_err) begin
            ovf <= 1'b0;
         end
         if (rd_rej) begin
            unf <= 1'b1;
         end else if (bus.clr_err) begin
            unf <= 1'b0;
         end
      end
   end

   assign bus.dout         = mem[ra_idx];
   assign bus.count        = cnt;
   assign bus.empty        = is_empty;
   assign bus.full         = is_full;
   assign bus.almost_empty = (cnt <= AE_CNT);
   assign bus.almost_full  = (cnt >= AF_CNT);
   assign bus.overflow     = ovf;
   assign bus.underflow    = unf;
endmodule

// File: tb/tb_prog_srl_fifo.sv
// tb_prog_srl_fifo
//   Directed and random stimulus for prog_srl_fifo (WIDTH=9, AW=4, AF=14,
//   AE=2). The stimulus thread pushes every accepted write into exp_q; a
//   separate monitor pops exp_q and checks dout whenever the DUT performs a
//   read. Status outputs are checked against a small reference model.
module tb_prog_srl_fifo;
   localparam int WIDTH = 9;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;

   prog_srl_fifo_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   prog_srl_fifo #(
      .WIDTH(WIDTH), .AW(AW), .AF_LEVEL(14), .AE_LEVEL(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [WIDTH-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int m_cnt = 0;
   bit m_ovf = 1'b0;
   bit m_unf = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a read is performed at the next edge when rd & ~empty & ~rst.
   always @(negedge clk) begin
      if (!rst && bus.rd && !bus.empty) begin
         if (exp_q.size() == 0) begin
            chk("rd_on_model_empty", 1, 0);
         end else begin
            chk("dout_pop", int'(bus.dout), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic check_status(input string tag);
      chk({tag, ":count"},  int'(bus.count),        m_cnt);
      chk({tag, ":empty"},  int'(bus.empty),        int'(m_cnt == 0));
      chk({tag, ":full"},   int'(bus.full),         int'(m_cnt == DEPTH));
      chk({tag, ":a_empty"},int'(bus.almost_empty), int'(m_cnt <= 2));
      chk({tag, ":a_full"}, int'(bus.almost_full),  int'(m_cnt >= 14));
      chk({tag, ":ovf"},    int'(bus.overflow),     int'(m_ovf));
      chk({tag, ":unf"},    int'(bus.underflow),    int'(m_unf));
      if (m_cnt > 0) begin
         chk({tag, ":head"}, int'(bus.dout), int'(exp_q[0]));
      end
   endtask

   // Drive one cycle (called at posedge+1), update the model, sample at posedge+1.
   task automatic step(input bit w, input bit r, input bit c,
                       input logic [WIDTH-1:0] d, input bit chk_en);
      bit wa, rok;
      bus.wr = w; bus.rd = r; bus.clr_err = c; bus.din = d;
      wa  = w && (m_cnt < DEPTH || r);
      rok = r && (m_cnt > 0);
      if (wa) exp_q.push_back(d);
      if (w && m_cnt == DEPTH && !r) m_ovf = 1'b1;
      else if (c)                    m_ovf = 1'b0;
      if (r && m_cnt == 0)           m_unf = 1'b1;
      else if (c)                    m_unf = 1'b0;
      m_cnt = m_cnt + int'(wa) - int'(rok);
      @(posedge clk); #1;
      bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0;
      if (chk_en) check_status("step");
   endtask

   task automatic do_reset(input bit w, input bit r);
      rst = 1'b1; bus.wr = w; bus.rd = r; bus.clr_err = 1'b0; bus.din = 9'h1FF;
      @(posedge clk); #1;
      rst = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
      exp_q.delete();
      m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   initial begin
      bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0; bus.din = '0;
      @(posedge clk); #1;
      do_reset(1'b0, 1'b0);
      chk("rst:count", int'(bus.count), 0);
      chk("rst:empty", int'(bus.empty), 1);
      chk("rst:a_empty", int'(bus.almost_empty), 1);
      chk("rst:full", int'(bus.full), 0);
      chk("rst:flags", int'({bus.overflow, bus.underflow, bus.almost_full}), 0);

      // Fill 0x001..0x010; almost_empty drops on the 3rd, almost_full on the 14th.
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 1'b0, 1'b0, 9'(i), 1'b1);
         chk("fill:a_empty", int'(bus.almost_empty), int'(i <= 2));
         chk("fill:a_full",  int'(bus.almost_full),  int'(i >= 14));
      end
      chk("fill:count16", int'(bus.count), 16);
      chk("fill:full", int'(bus.full), 1);
      chk("fill:head", int'(bus.dout), 9'h001);

      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 9'h0, 1'b1);
      chk("drain:empty", int'(bus.empty), 1);

      // Overflow at full, then clear.
      for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b0, 9'(8'h20 + i), 1'b0);
      step(1'b1, 1'b0, 1'b0, 9'h1AA, 1'b1);
      chk("ovf:count", int'(bus.count), 16);
      chk("ovf:flag", int'(bus.overflow), 1);
      chk("ovf:head", int'(bus.dout), 9'h021);
      step(1'b0, 1'b0, 1'b1, 9'h0, 1'b1);
      chk("ovf:clr", int'(bus.overflow), 0);

      // Simultaneous wr/rd at full: oldest popped, 0x155 becomes last.
      step(1'b1, 1'b1, 1'b0, 9'h155, 1'b1);
      chk("wrrd_full:count", int'(bus.count), 16);
      chk("wrrd_full:head", int'(bus.dout), 9'h022);
      for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 9'h0, 1'b1);
      chk("wrrd_full:last", int'(bus.dout), 9'h155);
      step(1'b0, 1'b1, 1'b0, 9'h0, 1'b1);

      // Simultaneous wr/rd at empty with clr_err: underflow wins.
      step(1'b1, 1'b1, 1'b1, 9'h0F0, 1'b1);
      chk("wrrd_empty:count", int'(bus.count), 1);
      chk("wrrd_empty:dout", int'(bus.dout), 9'h0F0);
      chk("wrrd_empty:unf", int'(bus.underflow), 1);
      step(1'b0, 1'b1, 1'b1, 9'h0, 1'b1);
      chk("unf:clr", int'(bus.underflow), 0);

      // Reset mid-operation with wr asserted.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 9'(8'h40 + i), 1'b0);
      step(1'b1, 1'b0, 1'b0, 9'h1AA, 1'b0);
      do_reset(1'b1, 1'b0);
      chk("rst_mid:count", int'(bus.count), 0);
      chk("rst_mid:empty", int'(bus.empty), 1);
      chk("rst_mid:flags", int'({bus.overflow, bus.underflow}), 0);
      step(1'b1, 1'b0, 1'b0, 9'h033, 1'b1);
      chk("rst_mid:dout", int'(bus.dout), 9'h033);
      chk("rst_mid:count1", int'(bus.count), 1);

      // Random traffic against the reference model.
      for (int i = 0; i < 10000; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 15) == 0), 9'($urandom), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
